// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder; ovf exists only with SERIAL_ADDER_OVF_EN.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB first, one bit per clock.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned  WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             bit_c;
  logic             carry_nx_c;
  logic             last_c;
  logic [WIDTH-1:0] res_shift_c;

  // Full-adder slice on the current LSBs
  assign bit_c       = sha_q[0] ^ shb_q[0] ^ carry_q;
  assign carry_nx_c  = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) | (shb_q[0] & carry_q);
  assign last_c      = (cnt_q == CNT_W'(WIDTH - 1));
  assign res_shift_c = (res_q >> 1) | (WIDTH'(bit_c) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: operand load on accepted start, shift/accumulate in RUN
  always_comb begin
    sha_d   = sha_q;
    shb_d   = shb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          sha_d   = bus.a;
          shb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        res_d   = res_shift_c;
        carry_d = carry_nx_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_c) begin
          sum_d  = res_shift_c;
          cout_d = carry_nx_c;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d  = carry_q ^ carry_nx_c;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor built around one full-adder slice and a registered carry.
- Accepts two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first. Presents sum, carry-out and a one-cycle done pulse.
- Used where a wide add is needed but area matters more than latency; the successor to the combinational adder cells.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = add (a + b + cin); 1 = subtract (a - b). Latched on start.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in for add; ignored when sub=1.
- busy  output  1  high while the operation is in progress (RUN).
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  final carry; in subtract mode 1 = no borrow, 0 = borrow.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

Behaviour:
- Reset: rst_n low at a clock edge forces state=IDLE, busy=0, done=0, sum=0, cout=0, carry reg=0, bit counter=0, ovf=0. Reset applies mid-operation too: the operation is abandoned and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE to RUN on an edge with start=1. At that edge:
  - shift_a is loaded with a.
  - shift_b is loaded with b (or ~b when sub=1).
  - carry is loaded with cin (or 1 when sub=1).
  - counter is cleared to 0 and busy goes to 1.
- RUN, at each edge:
  - s = shift_a[0] ^ shift_b[0] ^ carry.
  - carry <= majority(shift_a[0], shift_b[0], carry).
  - s is shifted into the result register MSB; result shifts right.
  - shift_a and shift_b shift right; counter increments.
- RUN to DONE on the edge where counter reaches WIDTH-1, i.e. after the WIDTH-th bit is processed. At that edge:
  - sum takes the full result.
  - cout takes the final carry.
  - busy goes to 0 and done goes to 1.
- Latency: start sampled at edge 0; done observed high after edge WIDTH; busy high after edges 1..WIDTH-1 inclusive of edge 0 update.
- DONE always leaves after one cycle, so done is high for exactly one cycle:
  - start=1: go to RUN and load new operands (back-to-back operation, no idle cycle).
  - start=0: go to IDLE.
- start in RUN is ignored: no restart, and latched operands are unaffected.
- a, b, sub and cin may change freely after the start edge.
- sum and cout retain their last values through IDLE and through the next RUN until that operation completes.
- WIDTH=1: RUN lasts one edge; done follows the start edge by one edge.
- Arithmetic is modulo 2^WIDTH; cout carries the bit 2^WIDTH.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- When defined:
  - Port ovf exists.
  - On the RUN to DONE edge, ovf <= carry_into_MSB ^ carry_out_of_MSB, the two's-complement overflow of the effective add.
  - ovf holds its value alongside sum; reset value 0.
- When undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, sub=0, a=0x5A, b=0x33, cin=0: done exactly 8 edges after start; sum=0x8D, cout=0; busy high for the preceding cycles.
- WIDTH=8, sub=0, a=0xFF, b=0x01, cin=0: sum=0x00, cout=1. With cin=1 and a=0xFF, b=0x00: sum=0x00, cout=1.
- WIDTH=8, sub=1, a=0x10, b=0x20, cin=1 (ignored): sum=0xF0, cout=0. Then a=0x20, b=0x10: sum=0x10, cout=1.
- Control sequencing:
  - start pulsed again at RUN cycle 3 with different operands: ignored, first result unchanged.
  - start held high in the DONE cycle: second operation runs back-to-back and its done arrives 8 edges later.
- Reset and boundary:
  - rst_n low during RUN cycle 4: all outputs 0 on the next edge, no done pulse, state IDLE.
  - WIDTH=1, a=1, b=1: sum=0, cout=1, done one edge after start.
- With SERIAL_ADDER_OVF_EN, WIDTH=8:
  - 0x7F+0x01: ovf=1, sum=0x80.
  - 0x80-0x01: ovf=1.
  - 0x05+0x03: ovf=0.
